mult_arb: RTL and testbench
===========================

MULT_ARB -- requirements
Module: mult_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing one multiply unit.
REQ-002 SHALL have parameter W, default 8, operand width; product width 2*W.
REQ-003 SHALL have parameter TMO, default 32, watchdog limit in clock cycles (used only with MULT_ARB_TMO_EN).
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  system clock, all state on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 req  input  NREQ  per-requester request level.
REQ-008 a_in  input  NREQ*W  packed operand A, requester i at bits [i*W +: W].
REQ-009 b_in  input  NREQ*W  packed operand B, same packing.
REQ-010 grant  output  NREQ  one-hot, high while requester i is being served.
REQ-011 done  output  NREQ  one-cycle pulse to the served requester when result is valid.
REQ-012 result  output  2*W  product, valid in the done cycle and held until next done.
REQ-013 err  output  1  one-cycle pulse on watchdog abort.
REQ-014 m_rst  output  1  reset to multiply unit.
REQ-015 m_start  output  1  start to multiply unit.
REQ-016 m_a, m_b  output  W each  operands to multiply unit, registered.
REQ-017 m_prod  input  2*W  product from multiply unit.
REQ-018 m_rdy  input  1  completion from multiply unit.

Function
REQ-019 FSM states SHALL be IDLE, CLEAR, RUN, DONE.
REQ-020 IDLE: if any req high, SHALL select winner round-robin starting after last served index, latch its a/b into m_a/m_b, set grant, go CLEAR; else stay.
REQ-021 CLEAR: SHALL assert m_rst for exactly one cycle, m_start low, go RUN.
REQ-022 RUN: SHALL hold m_start high, m_rst low; on m_rdy high SHALL capture m_prod into result, drop m_start, go DONE.
REQ-023 DONE: SHALL pulse done[winner] for one cycle, clear grant, advance pointer to winner+1 mod NREQ, go IDLE.
REQ-024 Minimum request-to-done latency SHALL be 3 cycles plus multiplier latency; next grant no earlier than cycle after DONE.
REQ-025 Requester SHALL hold req until its done; req dropped during service SHALL NOT abort the operation; req dropped before grant SHALL be ignored.
REQ-026 Operand changes after grant SHALL NOT affect the current product.
REQ-027 Simultaneous requests SHALL be served one at a time, each pending requester served within NREQ grants (no starvation).
REQ-028 Pointer wrap: after serving NREQ-1, search SHALL start at 0.
REQ-029 m_rdy outside RUN SHALL be ignored.

Reset
REQ-030 rst SHALL force IDLE, grant=0, done=0, err=0, result=0, m_start=0, m_a=m_b=0, pointer=0, m_rst=1 in the reset cycle.
REQ-031 rst mid-operation SHALL abandon the operation without a done pulse.

Configuration
REQ-032 Macro MULT_ARB_TMO_EN defined: cycle counter in RUN; if m_rdy absent for TMO cycles, SHALL pulse err and done[winner], set result=0, go DONE path (pointer advances).
REQ-033 Macro undefined: no counter, err tied 0, RUN waits indefinitely.

Structure
REQ-034 Package mult_arb_pkg SHALL hold the state enum and default NREQ/W/TMO constants.
REQ-035 Round-robin pick SHALL be a sub-module rr_pick (req vector + pointer -> one-hot grant, valid).

Verification
REQ-036 Single req[0], a=10, b=11 -> grant[0], one m_rst pulse, done[0] with result=110.
REQ-037 req[1] a=14 b=13 and req[2] a=24 b=34 same cycle, pointer 0 -> done[1] result=182 first, then done[2] result=816.
REQ-038 All four requesting continuously -> grant order 0,1,2,3,0; products 76*98=7448 on req 3.
REQ-039 rst asserted during RUN of 101*102 -> no done, outputs reset; re-request -> result=10302.
REQ-040 With MULT_ARB_TMO_EN, m_rdy held low -> err and done pulse after 32 RUN cycles, result=0; next requester then served.

Source files
------------

// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg -- shared types and default sizing for the multiply arbiter.
//   state_t  : arbiter FSM encoding (IDLE, CLEAR, RUN, DONE)
//   NREQ_DEF : default number of requesters
//   W_DEF    : default operand width (product is 2*W)
//   TMO_DEF  : default watchdog limit in RUN cycles (MULT_ARB_TMO_EN builds)
package mult_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int NREQ_DEF = 4;
  localparam int W_DEF    = 8;
  localparam int TMO_DEF  = 32;

endpackage

// File: rtl/rr_pick.sv
// rr_pick -- combinational round-robin selector.
//   req : request vector
//   ptr : index with highest priority this round (search starts here, wraps)
//   gnt : one-hot winner (all zero when no request)
//   vld : at least one request present
module rr_pick
  import mult_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic            vld
);

  // Outer loop walks priority distance from ptr, so the first hit is the
  // nearest requester at or after ptr, modulo NREQ.
  always_comb begin
    gnt = '0;
    vld = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!vld && req[i] && (i == (int'(ptr) + k) % NREQ)) begin
          gnt[i] = 1'b1;
          vld    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mult_arb.sv
// mult_arb -- round-robin arbiter sharing one external multiply unit among
// NREQ requesters.
//
// Optional feature: define MULT_ARB_TMO_EN to enable a RUN-state watchdog.
// After TMO RUN cycles without m_rdy the operation is aborted with err and
// done pulsed together and result forced to 0. Without the macro err is 0
// and RUN waits for m_rdy indefinitely.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   req[NREQ]       : request levels
//   a_in, b_in      : packed operands, requester i at [i*W +: W]
//   grant[NREQ]     : one-hot, high while requester is served
//   done[NREQ]      : one-cycle completion pulse to the served requester
//   result[2W]      : product, valid in the done cycle, held until next done
//   err             : one-cycle watchdog abort pulse
//   m_rst, m_start  : multiply unit control
//   m_a, m_b        : registered operands to multiply unit
//   m_prod, m_rdy   : multiply unit product and completion
//   state_dbg       : current FSM state (state_t encoding)
//
// Requester protocol: raise req and hold it with stable operands until
// grant; operands are captured at grant, so later changes or dropping req
// do not disturb the running operation. done[i] pulses once per service.
module mult_arb
  import mult_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF,
  parameter int TMO  = TMO_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] a_in,
  input  logic [NREQ*W-1:0] b_in,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic [2*W-1:0]    result,
  output logic              err,
  output logic              m_rst,
  output logic              m_start,
  output logic [W-1:0]      m_a,
  output logic [W-1:0]      m_b,
  input  logic [2*W-1:0]    m_prod,
  input  logic              m_rdy,
  output logic [1:0]        state_dbg
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (TMO < 1) begin : g_bad_tmo
    $error("mult_arb: TMO must be at least 1");
  end

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   win_idx;
  logic [NREQ-1:0] pick_gnt;
  logic            pick_vld;
  logic [PW-1:0]   pick_idx;
  logic [W-1:0]    pick_a;
  logic [W-1:0]    pick_b;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req (req),
    .ptr (ptr),
    .gnt (pick_gnt),
    .vld (pick_vld)
  );

  // Winner index and its operands, decoded from the one-hot pick.
  always_comb begin
    pick_idx = '0;
    pick_a   = '0;
    pick_b   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_gnt[i]) begin
        pick_idx = PW'(i);
        pick_a   = a_in[i*W +: W];
        pick_b   = b_in[i*W +: W];
      end
    end
  end

`ifdef MULT_ARB_TMO_EN
  localparam int CW = $clog2(TMO + 1);
  logic [CW-1:0] cnt;
`else
  assign err = 1'b0;
`endif

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      grant   <= '0;
      done    <= '0;
      result  <= '0;
      m_rst   <= 1'b1;
      m_start <= 1'b0;
      m_a     <= '0;
      m_b     <= '0;
      ptr     <= '0;
      win_idx <= '0;
`ifdef MULT_ARB_TMO_EN
      err     <= 1'b0;
      cnt     <= '0;
`endif
    end else begin
      done <= '0;
`ifdef MULT_ARB_TMO_EN
      err  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          m_rst   <= 1'b0;
          m_start <= 1'b0;
          if (pick_vld) begin
            grant   <= pick_gnt;
            win_idx <= pick_idx;
            m_a     <= pick_a;
            m_b     <= pick_b;
            m_rst   <= 1'b1;  // high for the single CLEAR cycle
            state   <= CLEAR;
          end
        end
        CLEAR: begin
          m_rst   <= 1'b0;
          m_start <= 1'b1;
`ifdef MULT_ARB_TMO_EN
          cnt     <= '0;
`endif
          state   <= RUN;
        end
        RUN: begin
          m_rst <= 1'b0;
          if (m_rdy) begin
            result  <= m_prod;
            done    <= grant;
            m_start <= 1'b0;
            state   <= DONE;
          end
`ifdef MULT_ARB_TMO_EN
          // cnt counts completed RUN cycles; this is the TMO-th one.
          else if (cnt == CW'(TMO - 1)) begin
            result  <= '0;
            done    <= grant;
            err     <= 1'b1;
            m_start <= 1'b0;
            state   <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        DONE: begin
          grant <= '0;
          ptr   <= (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_arb.sv
// tb_mult_arb -- directed bench for mult_arb with a behavioural multiply
// unit (fixed latency, can be stalled) and a done-event scoreboard.
module tb_mult_arb;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int LAT  = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] a_in, b_in;
  logic [NREQ-1:0]   grant, done;
  logic [2*W-1:0]    result;
  logic              err, m_rst, m_start, m_rdy;
  logic [W-1:0]      m_a, m_b;
  logic [2*W-1:0]    m_prod;
  logic [1:0]        state_dbg;

  mult_arb #(.NREQ(NREQ), .W(W), .TMO(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .grant     (grant),
    .done      (done),
    .result    (result),
    .err       (err),
    .m_rst     (m_rst),
    .m_start   (m_start),
    .m_a       (m_a),
    .m_b       (m_b),
    .m_prod    (m_prod),
    .m_rdy     (m_rdy),
    .state_dbg (state_dbg)
  );

  // behavioural multiply unit
  logic mdl_en    = 1'b1;
  logic mdl_rdy   = 1'b0;
  logic stray_rdy = 1'b0;
  int   mcnt      = 0;
  assign m_rdy = mdl_rdy | stray_rdy;

  always @(posedge clk) begin
    if (m_rst) begin
      mcnt    <= 0;
      mdl_rdy <= 1'b0;
      m_prod  <= '0;
    end else if (m_start && !mdl_rdy && mdl_en) begin
      if (mcnt == LAT - 1) begin
        mdl_rdy <= 1'b1;
        m_prod  <= m_a * m_b;
        mcnt    <= 0;
      end else begin
        mcnt <= mcnt + 1;
      end
    end else begin
      mdl_rdy <= 1'b0;
    end
  end

  // scoreboard
  int tests_run = 0;
  int fails     = 0;
  logic [2*W-1:0] exp_q[$];
  int             exp_idx_q[$];
  int done_cnt = 0, mrst_cnt = 0, run_cnt = 0, err_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (m_rst) mrst_cnt++;
      if (state_dbg == 2'd2) run_cnt++;
      if (err) err_cnt++;
      if (done != '0) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          logic [2*W-1:0] er;
          int ei;
          er = exp_q.pop_front();
          ei = exp_idx_q.pop_front();
          check("result", 32'(result), 32'(er));
          check("done_onehot", 32'(done), 32'd1 << ei);
          check("grant_at_done", 32'(grant), 32'd1 << ei);
        end
      end
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(2);
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    a_in[i*W +: W] = a;
    b_in[i*W +: W] = b;
  endtask

  task automatic expect_done(input logic [2*W-1:0] r, input int idx);
    exp_q.push_back(r);
    exp_idx_q.push_back(idx);
  endtask

  task automatic wait_dones(input int n, input int budget);
    int target;
    int k;
    target = done_cnt + n;
    k = 0;
    while (done_cnt < target && k < budget) begin
      step(1);
      k++;
    end
    if (done_cnt < target) check("timeout_done", 32'(done_cnt), 32'(target));
  endtask

  task automatic wait_state(input logic [1:0] st, input int budget);
    int k;
    k = 0;
    while (state_dbg != st && k < budget) begin
      step(1);
      k++;
    end
    if (state_dbg != st) check("timeout_state", 32'(state_dbg), 32'(st));
  endtask

  task automatic wait_grant(input int budget);
    int k;
    k = 0;
    while (grant == '0 && k < budget) begin
      step(1);
      k++;
    end
    if (grant == '0) check("timeout_grant", 32'(grant), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    int dc;
    req  = '0;
    a_in = '0;
    b_in = '0;

    // reset state
    step(2);
    check("rst_grant",   32'(grant),     32'd0);
    check("rst_done",    32'(done),      32'd0);
    check("rst_err",     32'(err),       32'd0);
    check("rst_result",  32'(result),    32'd0);
    check("rst_m_start", 32'(m_start),   32'd0);
    check("rst_m_rst",   32'(m_rst),     32'd1);
    check("rst_m_a",     32'(m_a),       32'd0);
    check("rst_m_b",     32'(m_b),       32'd0);
    check("rst_state",   32'(state_dbg), 32'd0);
    rst = 1'b0;
    step(2);

    // single requester; operands scrambled and req dropped after grant,
    // plus a short req[3] pulse that never reaches IDLE
    mrst_cnt = 0;
    set_op(0, 8'd10, 8'd11);
    expect_done(16'd110, 0);
    req[0] = 1'b1;
    wait_grant(10);
    set_op(0, 8'd99, 8'd99);
    req[0] = 1'b0;
    req[3] = 1'b1;
    step(1);
    req[3] = 1'b0;
    wait_dones(1, 50);
    check("m_rst_pulses", 32'(mrst_cnt), 32'd1);
    step(3);
    check("idle_after_single", 32'(state_dbg), 32'd0);
    check("grant_cleared", 32'(grant), 32'd0);

    // two simultaneous requests, pointer 0
    do_reset();
    set_op(1, 8'd14, 8'd13);
    set_op(2, 8'd24, 8'd34);
    expect_done(16'd182, 1);
    expect_done(16'd816, 2);
    req = 4'b0110;
    wait_dones(1, 50);
    req[1] = 1'b0;
    wait_dones(1, 50);
    req[2] = 1'b0;
    step(4);

    // all four continuously: order 0,1,2,3, wrap to 0
    do_reset();
    set_op(0, 8'd3,  8'd5);
    set_op(1, 8'd7,  8'd9);
    set_op(2, 8'd12, 8'd12);
    set_op(3, 8'd76, 8'd98);
    expect_done(16'd15,   0);
    expect_done(16'd63,   1);
    expect_done(16'd144,  2);
    expect_done(16'd7448, 3);
    expect_done(16'd15,   0);
    req = 4'b1111;
    wait_dones(5, 200);
    req = '0;
    dc = done_cnt;
    step(10);
    check("no_extra_done", 32'(done_cnt), 32'(dc));

    // reset in the middle of RUN
    do_reset();
    mdl_en = 1'b0;
    set_op(0, 8'd101, 8'd102);
    req[0] = 1'b1;
    wait_state(2'd2, 10);
    step(3);
    dc = done_cnt;
    rst = 1'b1;
    step(1);
    check("midrst_grant",   32'(grant),     32'd0);
    check("midrst_m_start", 32'(m_start),   32'd0);
    check("midrst_m_rst",   32'(m_rst),     32'd1);
    check("midrst_m_a",     32'(m_a),       32'd0);
    check("midrst_state",   32'(state_dbg), 32'd0);
    rst = 1'b0;
    step(1);
    check("midrst_no_done", 32'(done_cnt), 32'(dc));
    mdl_en = 1'b1;
    expect_done(16'd10302, 0);
    wait_dones(1, 50);
    req = '0;
    step(3);

    // multiplier stalled
    do_reset();
    set_op(0, 8'd5, 8'd6);
    set_op(1, 8'd7, 8'd8);
    mdl_en  = 1'b0;
    err_cnt = 0;
    run_cnt = 0;
`ifdef MULT_ARB_TMO_EN
    expect_done(16'd0, 0);
    expect_done(16'd56, 1);
    req = 4'b0011;
    wait_dones(1, 100);
    req[0] = 1'b0;
    mdl_en = 1'b1;
    check("tmo_err_pulses", 32'(err_cnt), 32'd1);
    check("tmo_run_cycles", 32'(run_cnt), 32'd32);
    wait_dones(1, 50);
    req = '0;
    step(3);
    check("tmo_single_err", 32'(err_cnt), 32'd1);
`else
    dc = done_cnt;
    req[0] = 1'b1;
    wait_state(2'd2, 10);
    step(40);
    check("stall_err",     32'(err_cnt),   32'd0);
    check("stall_state",   32'(state_dbg), 32'd2);
    check("stall_no_done", 32'(done_cnt),  32'(dc));
    mdl_en = 1'b1;
    expect_done(16'd30, 0);
    wait_dones(1, 50);
    req = '0;
    step(3);
`endif

    // stray m_rdy while idle is ignored
    dc = done_cnt;
    stray_rdy = 1'b1;
    step(3);
    stray_rdy = 1'b0;
    step(2);
    check("stray_no_done", 32'(done_cnt), 32'(dc));
    check("stray_state",   32'(state_dbg), 32'd0);
`ifdef MULT_ARB_TMO_EN
    check("stray_result",  32'(result), 32'd56);
`else
    check("stray_result",  32'(result), 32'd30);
`endif

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
